// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART core and its baud-tick divider.
//   uart_state_e : frame-level state, used by both the TX and the RX FSM
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of the stop bit (and of the idle line)
//   calc_div     : clocks per oversampling tick, integer-truncated
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int unsigned calc_div(input int unsigned clock_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned oversample);
        return clock_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider producing the oversampling tick.
//   clk  : system clock
//   rst  : synchronous, active-low reset (clears the counter)
//   tick : one-cycle pulse every DIV clocks (when the counter reaches DIV-1)
module uart_baud_gen #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_txrx.sv
// uart_txrx: full-duplex 8N1 UART (transmitter + receiver, shared baud tick).
//   clk          : system clock, rising edge
//   rst          : synchronous, active-low reset
//   tx_start     : send request, honoured only while the transmitter is idle
//   tx_data      : byte to send, captured when tx_start is accepted
//   tx           : serial output, idles high
//   tx_busy      : high from the accepted tx_start to the end of the stop bit
//   tx_done_tick : one-cycle pulse at the end of the stop bit
//   rx           : serial input (asynchronous, synchronised internally)
//   rx_data      : last correctly framed byte, held until the next one
//   rx_done_tick : one-cycle pulse when rx_data updates
//   rx_frame_err : one-cycle pulse when the stop bit samples low
module uart_txrx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DBIT       = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tx_start,
    input  logic [DBIT-1:0] tx_data,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done_tick,
    output logic            rx_frame_err
);

    localparam int unsigned DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);

    // Tick counter counts oversampling ticks within one bit.
    localparam int unsigned    SW     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [SW-1:0]  S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0]  S_MID  = SW'(OVERSAMPLE / 2 - 1);

    // Bit counter counts data bits within one frame.
    localparam int unsigned    NW     = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [NW-1:0]  N_LAST = NW'(DBIT - 1);

    logic tick;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_e     tx_state_q, tx_state_d;
    logic [SW-1:0]   tx_s_q, tx_s_d;
    logic [NW-1:0]   tx_n_q, tx_n_d;
    logic [DBIT-1:0] tx_b_q, tx_b_d;
    logic            tx_q, tx_d;
    logic            tx_done_q, tx_done_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_n_d     = tx_n_q;
        tx_b_d     = tx_b_q;
        tx_done_d  = 1'b0;

        unique case (tx_state_q)
            IDLE: begin
                if (tx_start) begin
                    tx_b_d     = tx_data;
                    tx_s_d     = '0;
                    tx_n_d     = '0;
                    tx_state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tx_s_q == S_LAST) begin
                        tx_s_d     = '0;
                        tx_n_d     = '0;
                        tx_state_d = DATA;
                    end else begin
                        tx_s_d = tx_s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tx_s_q == S_LAST) begin
                        tx_s_d = '0;
                        tx_b_d = tx_b_q >> 1;
                        if (tx_n_q == N_LAST) begin
                            tx_state_d = STOP;
                        end else begin
                            tx_n_d = tx_n_q + NW'(1);
                        end
                    end else begin
                        tx_s_d = tx_s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tx_s_q == S_LAST) begin
                        tx_done_d  = 1'b1;
                        tx_state_d = IDLE;
                    end else begin
                        tx_s_d = tx_s_q + SW'(1);
                    end
                end
            end
            default: tx_state_d = IDLE;
        endcase

        // Line level follows the next state so tx is glitch-free and registered.
        unique case (tx_state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = tx_b_d[0];
            default: tx_d = STOP_BIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= IDLE;
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_b_q     <= '0;
            tx_q       <= STOP_BIT;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_s_q     <= tx_s_d;
            tx_n_q     <= tx_n_d;
            tx_b_q     <= tx_b_d;
            tx_q       <= tx_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = (tx_state_q != IDLE);
    assign tx_done_tick = tx_done_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]      rx_sync_q;
    logic            rx_s;
    uart_state_e     rx_state_q, rx_state_d;
    logic [SW-1:0]   rx_s_q, rx_s_d;
    logic [NW-1:0]   rx_n_q, rx_n_d;
    logic [DBIT-1:0] rx_b_q, rx_b_d;
    logic [DBIT-1:0] rx_data_q, rx_data_d;
    logic            rx_done_q, rx_done_d;
    logic            rx_err_q, rx_err_d;

    assign rx_s = rx_sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_s_d     = rx_s_q;
        rx_n_d     = rx_n_q;
        rx_b_d     = rx_b_q;
        rx_data_d  = rx_data_q;
        rx_done_d  = 1'b0;
        rx_err_d   = 1'b0;

        unique case (rx_state_q)
            IDLE: begin
                // A held-low line restarts here at once, so a break keeps
                // producing framing errors.
                if (rx_s == START_BIT) begin
                    rx_s_d     = '0;
                    rx_state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s_q == S_MID) begin
                        if (rx_s == STOP_BIT) begin
                            rx_state_d = IDLE;          // too short: glitch
                        end else begin
                            rx_s_d     = '0;
                            rx_n_d     = '0;
                            rx_state_d = DATA;
                        end
                    end else begin
                        rx_s_d = rx_s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (rx_s_q == S_LAST) begin
                        rx_s_d = '0;
                        rx_b_d = {rx_s, rx_b_q[DBIT-1:1]};
                        if (rx_n_q == N_LAST) begin
                            rx_state_d = STOP;
                        end else begin
                            rx_n_d = rx_n_q + NW'(1);
                        end
                    end else begin
                        rx_s_d = rx_s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (rx_s_q == S_LAST) begin
                        if (rx_s == STOP_BIT) begin
                            rx_data_d = rx_b_q;
                            rx_done_d = 1'b1;
                        end else begin
                            rx_err_d = 1'b1;
                        end
                        rx_state_d = IDLE;
                    end else begin
                        rx_s_d = rx_s_q + SW'(1);
                    end
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= IDLE;
            rx_s_q     <= '0;
            rx_n_q     <= '0;
            rx_b_q     <= '0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], rx};
            rx_state_q <= rx_state_d;
            rx_s_q     <= rx_s_d;
            rx_n_q     <= rx_n_d;
            rx_b_q     <= rx_b_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_done_tick = rx_done_q;
    assign rx_frame_err = rx_err_q;

endmodule

// File: tb/tb_uart_txrx.sv
// tb_uart_txrx: randomized loopback and hand-driven checks of uart_txrx.
// Runs with a fast baud setting (DIV=10, 160 clocks per bit) so every
// scenario fits a short simulation; all timing is scaled from DIV.
module tb_uart_txrx;

    localparam int unsigned CLOCK_FREQ = 1_600_000;
    localparam int unsigned BAUD_RATE  = 10_000;
    localparam int unsigned DBIT       = 8;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned DIV        = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned BIT        = OVERSAMPLE * DIV;
    localparam int unsigned FRAME      = 10 * BIT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, tx_busy, tx_done_tick;
    logic       rx, rx_done_tick, rx_frame_err;
    logic [7:0] rx_data;
    logic       loop_en = 1'b1;
    logic       rx_drv = 1'b1;

    assign rx = loop_en ? tx : rx_drv;

    uart_txrx #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DBIT       (DBIT),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         tx_done_cnt = 0;
    int         rx_done_cnt = 0;
    int         rx_err_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    time        t_last_done = 0;
    logic       prev_txd = 1'b0, prev_rxd = 1'b0, prev_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every received byte must match the oldest byte sent.
    always @(negedge clk) begin
        if (rst) begin
            if (tx_done_tick) begin
                tx_done_cnt++;
                t_last_done = $time;
                check("tx_done_width", {31'd0, prev_txd}, 32'd0);
            end
            if (rx_done_tick) begin
                rx_done_cnt++;
                check("rx_done_width", {31'd0, prev_rxd}, 32'd0);
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, mon_exp});
                end else begin
                    check("rx_unexpected_byte", 32'(exp_q.size()), 32'd1);
                end
            end
            if (rx_frame_err) begin
                rx_err_cnt++;
                check("rx_err_width", {31'd0, prev_err}, 32'd0);
            end
        end
        prev_txd = tx_done_tick;
        prev_rxd = rx_done_tick;
        prev_err = rx_frame_err;
    end

    // Sends one byte in loopback and checks the line bit by bit at mid-bit.
    // Entered and left on a falling clock edge; leaves on the tx_done_tick cycle.
    task automatic send_frame(input logic [7:0] b, input bit inject, input bit check_gap);
        logic [9:0] frame;
        time        t_fall;
        bit         seen;
        int unsigned len;
        frame    = {1'b1, b, 1'b0};
        tx_data  = b;
        tx_start = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        tx_start = 1'b0;
        t_fall   = $time;
        check("tx_start_bit", {31'd0, tx}, 32'd0);
        check("tx_busy_set", {31'd0, tx_busy}, 32'd1);
        if (check_gap) check("b2b_gap_cycles", 32'((t_fall - t_last_done) / 10), 32'd1);
        repeat (BIT / 2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx_bit%0d", k), {31'd0, tx}, {31'd0, frame[k]});
            if (k == 4 && inject) begin
                tx_data  = 8'h3C;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (BIT - 1) @(negedge clk);
            end else if (k < 9) begin
                repeat (BIT) @(negedge clk);
            end
        end
        seen = 1'b0;
        for (int g = 0; g < 2 * BIT && !seen; g++) begin
            if (tx_done_tick) seen = 1'b1;
            else @(negedge clk);
        end
        check("tx_done_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            len = 32'(($time - t_fall) / 10) + 1;
            check("frame_len_in_tol",
                  {31'd0, (len + DIV >= FRAME) && (len <= FRAME + DIV)}, 32'd1);
            check("tx_busy_clear", {31'd0, tx_busy}, 32'd0);
        end
    endtask

    // Drives a frame on rx by hand; a bad stop bit is low for a little over half a bit.
    task automatic drive_frame(input logic [7:0] b, input bit good_stop);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        if (good_stop) exp_q.push_back(b);
        for (int k = 0; k < 9; k++) begin
            rx_drv = frame[k];
            repeat (BIT) @(negedge clk);
        end
        if (good_stop) begin
            rx_drv = 1'b1;
        end else begin
            rx_drv = 1'b0;
            repeat (BIT / 2 + 40) @(negedge clk);
            rx_drv = 1'b1;
        end
        repeat (2 * BIT) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lows;
        logic [7:0] r;

        // Reset state
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_tx_done", {31'd0, tx_done_tick}, 32'd0);
        check("rst_rx_done", {31'd0, rx_done_tick}, 32'd0);
        check("rst_rx_err", {31'd0, rx_frame_err}, 32'd0);
        rst = 1'b1;
        lows = 0;
        repeat (2000) begin
            @(negedge clk);
            if (!tx) lows++;
        end
        check("idle_tx_low_cycles", 32'(lows), 32'd0);
        check("idle_no_tx_done", 32'(tx_done_cnt), 32'd0);

        // Loopback 0xA5
        send_frame(8'hA5, 1'b0, 1'b0);
        repeat (BIT) @(negedge clk);
        check("a5_rx_count", 32'(rx_done_cnt), 32'd1);
        check("a5_tx_count", 32'(tx_done_cnt), 32'd1);
        check("a5_rx_data", {24'd0, rx_data}, 32'hA5);
        check("a5_no_err", 32'(rx_err_cnt), 32'd0);

        // Back-to-back 0x00 then 0xFF
        send_frame(8'h00, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1);
        repeat (BIT) @(negedge clk);
        check("b2b_rx_count", 32'(rx_done_cnt), 32'd3);
        check("b2b_rx_data", {24'd0, rx_data}, 32'hFF);

        // tx_start while busy is ignored
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        check("busy_tx_count", 32'(tx_done_cnt), 32'd4);
        check("busy_rx_count", 32'(rx_done_cnt), 32'd4);
        check("busy_rx_data", {24'd0, rx_data}, 32'h81);
        check("busy_idle", {31'd0, tx_busy}, 32'd0);

        // Random loopback bytes
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            send_frame(r, 1'b0, 1'b0);
            repeat ($urandom_range(0, 50)) @(negedge clk);
        end
        repeat (BIT) @(negedge clk);
        check("rand_rx_count", 32'(rx_done_cnt), 32'd8);
        check("rand_tx_count", 32'(tx_done_cnt), 32'd8);

        // Hand-driven receive
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        repeat (20) @(negedge clk);
        r = 8'($urandom);
        drive_frame(r, 1'b1);
        check("hand_rx_count", 32'(rx_done_cnt), 32'd9);
        check("hand_rx_data", {24'd0, rx_data}, {24'd0, r});

        // Short low glitch
        rx_drv = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("glitch_no_done", 32'(rx_done_cnt), 32'd9);
        check("glitch_no_err", 32'(rx_err_cnt), 32'd0);

        // Framing error keeps the previous byte
        drive_frame(8'h55, 1'b0);
        check("ferr_count", 32'(rx_err_cnt), 32'd1);
        check("ferr_no_done", 32'(rx_done_cnt), 32'd9);
        check("ferr_data_held", {24'd0, rx_data}, {24'd0, r});

        // Receiver recovered after glitch and framing error
        drive_frame(8'h5A, 1'b1);
        check("recover_rx_count", 32'(rx_done_cnt), 32'd10);
        check("recover_rx_data", {24'd0, rx_data}, 32'h5A);

        // Reset in the middle of a transmitted frame
        loop_en  = 1'b1;
        tx_data  = 8'hC3;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (3 * BIT + 7) @(negedge clk);
        check("midframe_busy", {31'd0, tx_busy}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_tx_high", {31'd0, tx}, 32'd1);
        check("midrst_busy", {31'd0, tx_busy}, 32'd0);
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (FRAME + 2 * BIT) @(negedge clk);
        check("midrst_no_tx_done", 32'(tx_done_cnt), 32'd8);
        check("midrst_no_rx_done", 32'(rx_done_cnt), 32'd10);
        check("midrst_no_err", 32'(rx_err_cnt), 32'd1);
        check("midrst_tx_idle", {31'd0, tx}, 32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
